// File: rtl/reg_file_ctrl_pkg.sv
// reg_file_ctrl_pkg
// Shared constants and types for the register-file write-port controller and
// the register file it feeds.
//   RF_DATA_WIDTH : register width
//   RF_ADDR_WIDTH : register address width (file holds 2^RF_ADDR_WIDTH entries)
//   RF_NUM_REGS   : number of registers
//   MAX_REQ       : largest supported requester count
//   PTR_WIDTH     : width of a requester index / round-robin pointer
//   state_t       : controller state encoding (CLEAR=0, RUN=1)
package reg_file_ctrl_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_REGS   = 1 << RF_ADDR_WIDTH;

  // Requester indices are sized for the largest supported count so the
  // pointer width never depends on NUM_REQ.
  localparam int MAX_REQ   = 8;
  localparam int PTR_WIDTH = $clog2(MAX_REQ);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_ctrl_if.sv
// reg_file_ctrl_if
// Write-request bus between the execute/memory/writeback sources and the
// register-file write-port controller.
//   req_valid : NUM_REQ bits, requester i presents a write
//   req_waddr : NUM_REQ x ADDR_WIDTH packed addresses, slice [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata : NUM_REQ x DATA_WIDTH packed data, sliced the same way
//   req_ready : NUM_REQ bits, one-hot grant (all zero when nothing granted)
// Modports: master = requesters, slave = controller.
import reg_file_ctrl_pkg::*;

interface reg_file_ctrl_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid,
    output req_waddr,
    output req_wdata,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_waddr,
    input  req_wdata,
    output req_ready
  );

endinterface

// File: rtl/reg_file_ctrl_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first asserted request
// found when searching upward from ptr, wrapping modulo NUM_REQ.
//   req : NUM_REQ bits, request vector
//   ptr : PTR_WIDTH bits, highest-priority index (must be < NUM_REQ)
//   gnt : NUM_REQ bits, one-hot grant, zero when no request is asserted
import reg_file_ctrl_pkg::*;

module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt
);

  always_comb begin : search
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr < NUM_REQ, so a single subtraction is enough to wrap.
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
// Write-port controller for the register file. After reset it sweeps
// registers 1..2^ADDR_WIDTH-1 to zero (the storage has no reset), then shares
// the single write port among NUM_REQ requesters with round-robin arbitration.
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-low reset
//   req_bus   : request bus (slave side): req_valid/req_waddr/req_wdata in,
//               req_ready (one-hot, combinational from req_valid and pointer) out
//   init_done : high once the clear sweep has finished (decode of RUN state)
//   rf_wen    : register file write enable (registered)
//   rf_waddr  : register file write address (registered)
//   rf_wdata  : register file write data (registered)
import reg_file_ctrl_pkg::*;

module reg_file_ctrl #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_ctrl_if.slave        req_bus,
  output logic                  init_done,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [PTR_WIDTH-1:0]  ptr;
  logic [PTR_WIDTH-1:0]  ptr_next;

  logic [NUM_REQ-1:0]    gnt;
  logic                  xfer;
  logic [PTR_WIDTH-1:0]  win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Unpack the flat request buses into per-requester arrays.
  logic [ADDR_WIDTH-1:0] req_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_addr_arr[gi] = req_bus.req_waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data_arr[gi] = req_bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_bus.req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      // The edge that issues the last address also leaves CLEAR.
      CLEAR:   if (clear_addr == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    init_done         = (state == RUN);
    req_bus.req_ready = (state == RUN) ? gnt : '0;
  end

  // A nonzero grant already implies the matching valid is high.
  assign xfer = (state == RUN) && (|gnt);

  // One-hot grant to index plus payload select.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PTR_WIDTH'(i);
        win_addr = req_addr_arr[i];
        win_data = req_data_arr[i];
      end
    end
  end

  assign ptr_next = (win_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // ---------------- Clear counter, pointer, write-port registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_addr <= ADDR_WIDTH'(1);
      ptr        <= '0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else if (state == CLEAR) begin
      rf_wen     <= 1'b1;
      rf_waddr   <= clear_addr;
      rf_wdata   <= '0;
      clear_addr <= clear_addr + 1'b1;
    end else if (xfer) begin
      // Address 0 is hardwired in the file: accept the handshake, drop the write.
      rf_wen   <= (win_addr != '0);
      rf_waddr <= win_addr;
      rf_wdata <= win_data;
      ptr      <= ptr_next;
    end else begin
      rf_wen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl
// Directed self-checking bench for reg_file_ctrl with NUM_REQ=3. A small
// behavioural register file sits on the rf_* outputs so that committed
// contents can be checked as well as the port values.
`timescale 1ns/1ps

module tb_reg_file_ctrl;

  localparam int NUM_REQ = 3;
  localparam int DW      = 32;
  localparam int AW      = 5;

  logic          clk;
  logic          rst;
  logic          init_done;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  reg_file_ctrl_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_bus   (bus.slave),
    .init_done (init_done),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file with no reset; seeded with junk at the first
  // edge so the sweep has something to clear. Register 0 starts at 0.
  logic [DW-1:0] mem [32];
  logic          seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'h0 : (32'hBAD0_0000 + 32'(i));
      seeded <= 1'b1;
    end else if (rf_wen) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_waddr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    rst           = 1'b0;
    bus.req_valid = '1;
    bus.req_waddr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, AW'(3 + i), 32'h1111_0000 + 32'(i));

    // ---- Reset values ----
    tick();
    tick();
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);

    // ---- Sweep with all requesters valid ----
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sweep_ready_pre", 32'(bus.req_ready), 32'd0);
    for (int e = 1; e <= 31; e++) begin
      tick();
      chk($sformatf("sweep%0d_waddr", e), 32'(rf_waddr), 32'(e));
      chk($sformatf("sweep%0d_wen", e), 32'(rf_wen), 32'd1);
      chk($sformatf("sweep%0d_wdata", e), rf_wdata, 32'd0);
      chk($sformatf("sweep%0d_init", e), 32'(init_done), (e == 31) ? 32'd1 : 32'd0);
      chk($sformatf("sweep%0d_ready", e), 32'(bus.req_ready), (e == 31) ? 32'd1 : 32'd0);
    end
    bus.req_valid = '0;
    tick();
    tick();
    chk("idle_wen", 32'(rf_wen), 32'd0);
    chk("idle_waddr_hold", 32'(rf_waddr), 32'd31);
    for (int i = 0; i < 32; i++) chk($sformatf("clear_mem%0d", i), mem[i], 32'd0);

    // ---- Single requester ----
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    bus.req_valid = 3'b010;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = '0;
    chk("single_wen", 32'(rf_wen), 32'd1);
    chk("single_waddr", 32'(rf_waddr), 32'd5);
    chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);

    // ---- Address zero (pointer now 2) ----
    set_req(2, 5'd0, 32'h1234_5678);
    bus.req_valid = 3'b100;
    #1;
    chk("a0_ready", 32'(bus.req_ready), 32'b100);
    tick();
    bus.req_valid = '0;
    chk("a0_wen", 32'(rf_wen), 32'd0);
    chk("a0_waddr", 32'(rf_waddr), 32'd0);
    chk("a0_wdata", rf_wdata, 32'h1234_5678);
    tick();
    chk("a0_mem0", mem[0], 32'd0);
    chk("single_mem5", mem[5], 32'hDEAD_BEEF);

    // ---- Round-robin from pointer 0 ----
    for (int i = 0; i < NUM_REQ; i++) set_req(i, AW'(10 + i), 32'hC0DE_0000 + 32'(i));
    bus.req_valid = 3'b111;
    #1;
    chk("rr_ready0", 32'(bus.req_ready), 32'b001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr%0d_wen", k), 32'(rf_wen), 32'd1);
      chk($sformatf("rr%0d_waddr", k), 32'(rf_waddr), 32'(10 + k % 3));
      chk($sformatf("rr%0d_wdata", k), rf_wdata, 32'hC0DE_0000 + 32'(k % 3));
      if (k < 5) chk($sformatf("rr%0d_ready", k + 1), 32'(bus.req_ready), 32'(1 << ((k + 1) % 3)));
    end
    bus.req_valid = '0;
    tick();
    chk("rr_gap_wen", 32'(rf_wen), 32'd0);
    chk("rr_mem12", mem[12], 32'hC0DE_0002);

    // ---- Collision on address 7 (pointer 0) ----
    set_req(0, 5'd7, 32'hA);
    set_req(1, 5'd7, 32'hB);
    bus.req_valid = 3'b011;
    #1;
    chk("coll_ready0", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b010;
    chk("coll_waddr0", 32'(rf_waddr), 32'd7);
    chk("coll_wdata0", rf_wdata, 32'hA);
    #1;
    chk("coll_ready1", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = '0;
    chk("coll_wdata1", rf_wdata, 32'hB);
    tick();
    tick();
    chk("coll_mem7", mem[7], 32'hB);

    // ---- Reset during RUN with a write pending (pointer 2) ----
    set_req(0, 5'd9, 32'h55);
    bus.req_valid = 3'b001;
    #1;
    chk("mr_ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b111;
    chk("mr_wen_pre", 32'(rf_wen), 32'd1);
    chk("mr_waddr_pre", 32'(rf_waddr), 32'd9);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_wen_rst", 32'(rf_wen), 32'd0);
    chk("mr_init_rst", 32'(init_done), 32'd0);
    chk("mr_ready_rst", 32'(bus.req_ready), 32'd0);
    tick();
    chk("mr_mem9", mem[9], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mr_restart_waddr", 32'(rf_waddr), 32'd1);
    chk("mr_restart_wen", 32'(rf_wen), 32'd1);
    chk("mr_restart_init", 32'(init_done), 32'd0);
    chk("mr_restart_ready", 32'(bus.req_ready), 32'd0);

    // ---- Reset mid-sweep at address 12 ----
    for (int e = 2; e <= 12; e++) tick();
    chk("ms_waddr_pre", 32'(rf_waddr), 32'd12);
    #2;
    rst = 1'b0;
    #1;
    chk("ms_wen_rst", 32'(rf_wen), 32'd0);
    chk("ms_waddr_rst", 32'(rf_waddr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("ms_restart_waddr", 32'(rf_waddr), 32'd1);
    chk("ms_restart_init", 32'(init_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Write-port controller for the 32×32 register file. After reset it sweeps registers 1..31 to zero, since the register file storage itself has no reset. It then shares the file's single write port among `NUM_REQ` requesters using a valid/ready handshake and round-robin arbitration. It sits between the execute/memory/writeback sources and the register file's `wen`/`waddr`/`wdata` inputs; the read ports are not touched.

## Interface
- `NUM_REQ`, default 3: number of write requesters, from 2 to 8.
- `DATA_WIDTH`, default 32: register width.
- `ADDR_WIDTH`, default 5: register address width; the file holds 2^`ADDR_WIDTH` entries.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, `NUM_REQ` bits: bit i means requester i presents a write.
- `req_waddr` input, `NUM_REQ`×`ADDR_WIDTH` bits: packed addresses; requester i occupies slice [i*`ADDR_WIDTH` +: `ADDR_WIDTH`].
- `req_wdata` input, `NUM_REQ`×`DATA_WIDTH` bits: packed data, sliced the same way.
- `req_ready` output, `NUM_REQ` bits: one-hot grant; all zero when no grant is given.
- `init_done` output, 1 bit: high once the clear sweep has finished.
- `rf_wen` output, 1 bit: drives the register file `wen`.
- `rf_waddr` output, `ADDR_WIDTH` bits: drives the register file `waddr`.
- `rf_wdata` output, `DATA_WIDTH` bits: drives the register file `wdata`.

## Operation
- **States:** `CLEAR` and `RUN`.
- **Reset values:** state=`CLEAR`, clear address=1, round-robin pointer=0, `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `init_done`=0, `req_ready`=0.
- **`CLEAR` state:**
  - `req_ready` is held at 0.
  - Each edge: `rf_wen`<=1, `rf_waddr`<=clear address, `rf_wdata`<=0, clear address increments.
  - On the edge that issues address 2^`ADDR_WIDTH`−1, state<=`RUN`.
  - Address 0 is never issued.
- **`RUN` state:**
  - `init_done`=1 (a decode of state, no extra register).
  - Winner = the first i with `req_valid[i]`=1, searching from the pointer upward and wrapping modulo `NUM_REQ`.
  - `req_ready[winner]`=1, driven combinationally from `req_valid` and the pointer.
  - A transfer happens on an edge where `req_valid[i]` and `req_ready[i]` are both 1.
- **On a transfer:**
  - `rf_waddr`<=winner address, `rf_wdata`<=winner data.
  - `rf_wen`<=1 only if the address is nonzero. A write to address 0 is accepted (handshake completes) and then dropped.
  - Pointer<=(winner+1) mod `NUM_REQ`.
- **No valid request:** `rf_wen`<=0; `rf_waddr`/`rf_wdata` hold their values; the pointer holds.
- **Requester obligation:** a requester keeps `req_valid` and its payload stable until accepted. The controller does not check this.
- **Multiple requests, same address:** only one grant is given per cycle. Writes land in grant order, so the last one granted wins.
- **Reset mid-sweep or mid-run:** everything returns to the reset values immediately, asynchronously. The sweep restarts at address 1. An in-flight registered write is cancelled because `rf_wen` drops to 0.

## Timing
- Clear sweep: addresses 1..31 appear on `rf_*` after edges 1..31 following reset release. `init_done` rises after edge 31; the register file commits address 31 at edge 32.
- Accepting a request: payload on `rf_*` one edge after acceptance; committed in the register file at the next edge after that. Acceptance-to-visible-in-file is 2 cycles.
- Throughput: one write per cycle, sustained.
- Fairness: a valid requester is granted within `NUM_REQ` cycles.
- The only combinational paths are `req_valid` → `req_ready`. `rf_*` outputs are fully registered.

## Structure
- A shared package holds `DATA_WIDTH`, `ADDR_WIDTH`, the state encoding (`CLEAR`=0, `RUN`=1) and the packed-slice helper widths. The register file uses the same constants.
- Sub-module `rr_arbiter`: parameterised by `NUM_REQ`; inputs `req` and `ptr`, output one-hot `gnt`. Purely combinational. The pointer register stays in `reg_file_ctrl`.
- `reg_file_ctrl` contains the state machine, clear counter, pointer and output registers.

## Test plan
All scenarios use `NUM_REQ`=3.
- **Reset and sweep:** release `rst`, with all `req_valid` high throughout.
  - `req_ready`=0 for 31 cycles; `rf_waddr` steps 1..31 with `rf_wen`=1 and `rf_wdata`=0.
  - `init_done` rises after edge 31.
  - Reading the file afterwards returns 0 from every address.
- **Single requester:** requester 1 writes addr 5, data 0xDEADBEEF. `req_ready`=3'b010 that cycle; `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF one cycle later.
- **Round-robin:** all three requesters hold `req_valid` for 6 cycles from pointer=0. Grants go 0,1,2,0,1,2, one write per cycle, with no gaps on `rf_wen`.
- **Address zero:** requester 2 writes addr 0, data 0x12345678. Handshake completes, `rf_wen` stays 0, and register 0 still reads 0.
- **Collision:** requesters 0 and 1 both target addr 7, with data 0xA and 0xB, pointer=0. Register 7 ends up holding 0xB.
- **Mid-operation reset:** assert `rst` during the sweep at address 12, and again during `RUN` while a write is pending.
  - `rf_wen` drops to 0 immediately.
  - After release, the sweep restarts at address 1 and `init_done` is 0.
